// File: rtl/uart_tx_serializer.sv
// Asynchronous serial transmitter: accepts one word per ready/valid handshake and
// shifts it out as start bit, DATA_BITS data bits (LSB first) and STOP_BITS stop bits.
module uart_tx_serializer #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_in_valid,
  output logic                 io_in_ready,
  input  logic [DATA_BITS-1:0] io_in_bits,
  input  logic [DIV_WIDTH-1:0] io_div,
  output logic                 io_txd,
  output logic                 io_busy
);

  localparam int CNT_W = $clog2(DATA_BITS) + 1;
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] shift_q;
  logic [DIV_WIDTH-1:0] div_q;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [CNT_W-1:0]     bit_cnt;
  logic                 txd_q;
  logic                 busy_q;

  logic bit_end;
  logic accept;
  logic shift_en;

  // The counter counts div_q..0, so a bit lasts div_q+1 cycles and never wraps.
  assign bit_end     = (div_cnt == '0);
  assign io_in_ready = (state == IDLE) && !reset;
  assign accept      = io_in_ready && io_in_valid;
  assign shift_en    = (state == DATA) && bit_end && !reset;

  assign io_txd  = txd_q;
  assign io_busy = busy_q;

  // NOTE: the frame word and captured divisor carry no reset; they are only
  // consumed after an accept has loaded them, so resetting them buys nothing.
  always_ff @(posedge clock) begin
    if (accept) begin
      shift_q <= io_in_bits;
      div_q   <= io_div;
    end else if (shift_en) begin
      shift_q <= shift_q >> 1;
    end
  end

  // NOTE: every state register here uses <= so all of them see the same
  // pre-edge values; a blocking assignment would leak updates into later reads.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io_in_valid) begin
            state   <= START;
            div_cnt <= io_div;
            bit_cnt <= '0;
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end

        START: begin
          if (bit_end) begin
            state   <= DATA;
            div_cnt <= div_q;
            bit_cnt <= '0;
            txd_q   <= shift_q[0];
          end else begin
            div_cnt <= div_cnt - DIV_WIDTH'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            div_cnt <= div_q;
            if (bit_cnt == LAST_DATA) begin
              state   <= STOP;
              bit_cnt <= '0;
              txd_q   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              // Next bit comes from the word as it will be after this shift.
              txd_q   <= shift_q[1];
            end
          end else begin
            div_cnt <= div_cnt - DIV_WIDTH'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            if (bit_cnt == LAST_STOP) begin
              state   <= IDLE;
              bit_cnt <= '0;
              busy_q  <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              div_cnt <= div_q;
            end
            txd_q <= 1'b1;
          end else begin
            div_cnt <= div_cnt - DIV_WIDTH'(1);
          end
        end

        default: begin
          state  <= IDLE;
          txd_q  <= 1'b1;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: two instances (1 and 2 stop bits), a
// handshake tracker that queues expected frames, and a per-cycle waveform monitor.
module tb_uart_tx_serializer;

  localparam int NI = 2;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] div;
  } frame_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       valid [NI];
  logic [7:0] bits  [NI];
  logic [3:0] divv  [NI];
  logic       rdy   [NI];
  logic       txd   [NI];
  logic       busy  [NI];

  int     checks   = 0;
  int     failures = 0;
  int     hs_cnt [NI];
  frame_t sb_q   [NI][$];
  bit     wave   [NI][$];
  frame_t trk_f;

  always #5 clock = ~clock;

  uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1), .DIV_WIDTH(4)) u_dut0 (
    .clock       (clock),
    .reset       (reset),
    .io_in_valid (valid[0]),
    .io_in_ready (rdy[0]),
    .io_in_bits  (bits[0]),
    .io_div      (divv[0]),
    .io_txd      (txd[0]),
    .io_busy     (busy[0])
  );

  uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(2), .DIV_WIDTH(4)) u_dut1 (
    .clock       (clock),
    .reset       (reset),
    .io_in_valid (valid[1]),
    .io_in_ready (rdy[1]),
    .io_in_bits  (bits[1]),
    .io_div      (divv[1]),
    .io_txd      (txd[1]),
    .io_busy     (busy[1])
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Expected line level for every cycle of a frame, straight from the framing rules.
  function automatic void expand(input int k, input frame_t f);
    bit lv[$];
    int stop_bits;
    stop_bits = (k == 0) ? 1 : 2;
    lv.push_back(1'b0);
    for (int i = 0; i < 8; i++) lv.push_back(f.data[i]);
    for (int s = 0; s < stop_bits; s++) lv.push_back(1'b1);
    foreach (lv[i]) begin
      for (int c = 0; c <= int'(f.div); c++) wave[k].push_back(lv[i]);
    end
  endfunction

  // Handshake tracker: a frame is owed whenever valid and ready meet at an edge.
  always @(posedge clock) begin
    for (int k = 0; k < NI; k++) begin
      if (reset) begin
        sb_q[k].delete();
        wave[k].delete();
      end else if (valid[k] === 1'b1 && rdy[k] === 1'b1) begin
        trk_f.data = bits[k];
        trk_f.div  = divv[k];
        sb_q[k].push_back(trk_f);
        hs_cnt[k]++;
      end
    end
  end

  // Monitor: compares line, busy and ready every cycle against the expected waveform.
  initial begin
    bit exp_txd;
    bit in_frame;
    @(posedge clock);
    forever begin
      @(negedge clock);
      for (int k = 0; k < NI; k++) begin
        if (wave[k].size() == 0 && sb_q[k].size() != 0) expand(k, sb_q[k].pop_front());
        in_frame = (wave[k].size() != 0);
        exp_txd  = in_frame ? wave[k].pop_front() : 1'b1;
        check($sformatf("txd%0d", k), int'(txd[k]), int'(exp_txd));
        check($sformatf("busy%0d", k), int'(busy[k]), int'(in_frame));
        check($sformatf("ready%0d", k), int'(rdy[k]), int'(!in_frame && !reset));
      end
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send(input int k, input logic [7:0] d, input logic [3:0] dv, input bit hold);
    int c;
    int n;
    c = hs_cnt[k];
    n = 0;
    valid[k] = 1'b1;
    bits[k]  = d;
    divv[k]  = dv;
    while (hs_cnt[k] == c && n < 2000) begin
      idle_cycles(1);
      n++;
    end
    check($sformatf("handshake%0d", k), hs_cnt[k] - c, 1);
    if (!hold) valid[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while ((wave[k].size() != 0 || sb_q[k].size() != 0) && n < 3000) begin
      idle_cycles(1);
      n++;
    end
    check($sformatf("drain%0d", k), wave[k].size() + sb_q[k].size(), 0);
    idle_cycles(1);
  endtask

  task automatic random_traffic(input int k, input int frames);
    for (int i = 0; i < frames; i++) begin
      idle_cycles($urandom_range(0, 4));
      send(k, 8'($urandom), 4'($urandom_range(0, (k == 0) ? 15 : 7)), 1'($urandom_range(0, 1)));
    end
    valid[k] = 1'b0;
    wait_idle(k);
  endtask

  initial begin
    int base;
    for (int k = 0; k < NI; k++) begin
      valid[k]  = 1'b0;
      bits[k]   = 8'h00;
      divv[k]   = 4'h0;
      hs_cnt[k] = 0;
    end
    reset = 1'b1;
    idle_cycles(3);
    reset = 1'b0;

    // Quiet line after reset release.
    idle_cycles(20);

    // 0xA5 with 4-cycle bits; divisor input changes mid-frame and must be ignored.
    send(0, 8'hA5, 4'd3, 1'b0);
    idle_cycles(10);
    divv[0] = 4'd7;
    wait_idle(0);
    send(0, 8'h3C, 4'd7, 1'b0);
    wait_idle(0);

    // Back-to-back single-cycle bits with valid held high: exactly two frames.
    base = hs_cnt[0];
    send(0, 8'h00, 4'd0, 1'b1);
    send(0, 8'hFF, 4'd0, 1'b1);
    valid[0] = 1'b0;
    wait_idle(0);
    check("held_valid_handshakes", hs_cnt[0] - base, 2);

    // Two stop bits, 2-cycle bits, 0x01: 22-cycle frame.
    send(1, 8'h01, 4'd1, 1'b0);
    wait_idle(1);

    // Largest divisor: 16 cycles per bit.
    send(0, 8'h5A, 4'hF, 1'b0);
    wait_idle(0);

    // Reset during data bit 3, then a clean frame.
    send(0, 8'hC3, 4'd3, 1'b0);
    idle_cycles(16);
    reset = 1'b1;
    idle_cycles(1);
    reset = 1'b0;
    idle_cycles(2);
    send(0, 8'h96, 4'd3, 1'b0);
    wait_idle(0);

    // Reset and valid together: nothing may be accepted.
    base = hs_cnt[0];
    reset    = 1'b1;
    valid[0] = 1'b1;
    bits[0]  = 8'hE7;
    idle_cycles(2);
    reset    = 1'b0;
    valid[0] = 1'b0;
    idle_cycles(5);
    check("reset_valid_no_accept", hs_cnt[0] - base, 0);

    // Randomized traffic on both instances concurrently.
    fork
      random_traffic(0, 25);
      random_traffic(1, 25);
    join

    idle_cycles(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
